// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and constants for the fetch-address generator
//
// Contents:
//   pc_state_e            BOOT / RUN / FLUSH fetch-generator states
//   ILEN_STD, ILEN_C      byte lengths of standard and compressed instructions
//   DEFAULT_RESET_VECTOR  reset PC used when the instantiation does not override it
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_e;

    localparam int unsigned ILEN_STD = 4;
    localparam int unsigned ILEN_C   = 2;

    // Wide enough for any XLEN in use; the top casts it down to XLEN.
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage

// File: rtl/pc_align_chk.sv
// rtl/pc_align_chk.sv - combinational redirect-target misalignment detector
//
// Build option: PC_RVC_EN (defined: 2-byte alignment, undefined: 4-byte alignment)
//
// Ports:
//   addr_lsb    in   2  low two bits of the candidate target address
//   misaligned  out  1  target violates the instruction alignment of this build
module pc_align_chk (
    input  logic [1:0] addr_lsb,
    output logic       misaligned
);

`ifdef PC_RVC_EN
    localparam logic NEED_WORD_ALIGN = 1'b0;
`else
    localparam logic NEED_WORD_ALIGN = 1'b1;
`endif

    // Bit 0 is always illegal; bit 1 only matters when compressed code is off.
    assign misaligned = addr_lsb[0] | (NEED_WORD_ALIGN & addr_lsb[1]);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage fetch PC generator with redirect, trap and epoch tagging
//
// Build option: PC_RVC_EN (compressed instructions: 2-byte increments and alignment)
//
// Parameters: XLEN (PC width), RESET_VECTOR (PC at reset), EPOCH_W (epoch width)
//
// Ports:
//   clk                in   1        clock, rising edge
//   rst                in   1        asynchronous active-low reset
//   fetch_ready_i      in   1        instruction memory accepts pc_o this cycle
//   stall_i            in   1        pipeline stall, PC holds
//   redirect_valid_i   in   1        branch/jump taken in EX
//   redirect_target_i  in   XLEN     branch/jump target
//   trap_i             in   1        trap taken
//   mtvec_i            in   XLEN     trap vector base
//   is_compressed_i    in   1        current fetch is 16-bit (PC_RVC_EN only)
//   pc_o               out  XLEN     current fetch address
//   pc_valid_o         out  1        pc_o is a valid fetch request
//   epoch_o            out  EPOCH_W  epoch tag of the current fetch
//   misalign_o         out  1        pulse: misaligned redirect target discarded
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int                EPOCH_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_ready_i,
    input  logic               stall_i,
    input  logic               redirect_valid_i,
    input  logic [XLEN-1:0]    redirect_target_i,
    input  logic               trap_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic               is_compressed_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               pc_valid_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               misalign_o
);

`ifdef PC_RVC_EN
    localparam logic RVC_EN = 1'b1;
`else
    localparam logic RVC_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] INC_STD   = XLEN'(ILEN_STD);
    localparam logic [XLEN-1:0] INC_C     = XLEN'(ILEN_C);
    localparam logic [XLEN-1:0] TRAP_MASK = ~XLEN'(3);

    pc_state_e          state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               misalign_q, misalign_d;

    logic               target_misaligned;
    logic               transfer;
    logic [XLEN-1:0]    pc_inc;

    pc_align_chk u_align_chk (
        .addr_lsb   (redirect_target_i[1:0]),
        .misaligned (target_misaligned)
    );

    assign transfer = (state_q == ST_RUN) && fetch_ready_i && !stall_i;
    assign pc_inc   = (RVC_EN && is_compressed_i) ? INC_C : INC_STD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epoch_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            misalign_q <= misalign_d;
        end
    end

    // Priority: trap > redirect > hold > advance. A misaligned redirect still
    // wins over advance: it freezes the PC so the trap raised later reports it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        misalign_d = 1'b0;

        if (trap_i) begin
            pc_d    = mtvec_i & TRAP_MASK;
            epoch_d = epoch_q + EPOCH_W'(1);
            state_d = ST_FLUSH;
        end else if (redirect_valid_i) begin
            if (target_misaligned) begin
                misalign_d = 1'b1;
            end else begin
                pc_d    = redirect_target_i;
                epoch_d = epoch_q + EPOCH_W'(1);
                state_d = ST_FLUSH;
            end
        end else begin
            unique case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_FLUSH: state_d = ST_RUN;
                ST_RUN: begin
                    if (transfer) begin
                        pc_d = pc_q + pc_inc;
                    end
                end
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == ST_RUN);
    assign epoch_o    = epoch_q;
    assign misalign_o = misalign_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the IF stage of the pipelined core. It holds the architectural fetch PC in a register and advances it sequentially under a valid/ready handshake with instruction memory. It accepts branch/jump redirects from EX and trap redirects from the exception logic, and tags each fetch with an epoch so downstream stages can drop wrong-path instructions.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, PC loaded at reset.
- EPOCH_W, 2, epoch counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_ready_i  in  1  instruction memory can accept the address on pc_o this cycle.
- stall_i  in  1  pipeline stall; PC holds.
- redirect_valid_i  in  1  branch/jump taken in EX.
- redirect_target_i  in  XLEN  branch/jump target.
- trap_i  in  1  trap taken.
- mtvec_i  in  XLEN  trap vector base.
- is_compressed_i  in  1  current fetch is a 16-bit instruction (used only with PC_RVC_EN).
- pc_o  out  XLEN  current fetch address.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- epoch_o  out  EPOCH_W  epoch tag of the current fetch.
- misalign_o  out  1  one-cycle pulse: a redirect target was misaligned and was discarded.

## Operation
- States: BOOT, RUN, FLUSH.
- Reset (rst=0): state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, epoch_o=0, misalign_o=0.
- BOOT: lasts one cycle after reset release, then goes to RUN. pc_valid_o=0.
- RUN: pc_valid_o=1.
- FLUSH: lasts one bubble cycle, then goes to RUN. pc_valid_o=0.
- Priority per cycle: trap_i > redirect_valid_i > hold > advance.
- Trap: allowed in any state.
  - pc <= mtvec_i with bits [1:0] forced to 0.
  - epoch <= epoch+1.
  - state <= FLUSH.
  - A redirect in the same cycle is ignored.
- Redirect with an aligned target: allowed in any state.
  - pc <= redirect_target_i.
  - epoch <= epoch+1.
  - state <= FLUSH.
- Redirect with a misaligned target:
  - pc, epoch and state are unchanged.
  - misalign_o=1 for the next cycle.
  - The trap is raised externally later.
- Hold: in RUN, the PC holds when stall_i=1 or fetch_ready_i=0.
- Advance: a transfer is pc_valid_o && fetch_ready_i && !stall_i. On a transfer, pc <= pc+increment.
- Increment rule: 4, or 2 when PC_RVC_EN is defined and is_compressed_i=1.
- Arithmetic: modulo 2^XLEN. 0xFFFF_FFFC+4 wraps to 0 with no flag.
- Epoch wraps modulo 2^EPOCH_W.
- A redirect or trap while in FLUSH restarts FLUSH: one more bubble cycle, new target.

## Timing
- Registered outputs only; no combinational input-to-output paths.
- Redirect or trap in cycle N:
  - N+1: pc_o=target, epoch_o incremented, pc_valid_o=0.
  - N+2: pc_valid_o=1.
- Transfer in cycle N: pc_o is updated at N+1. Sequential throughput is one fetch per cycle.
- Reset release at edge E: pc_valid_o=1 from edge E+1.
- Asserting rst mid-operation clears all state immediately, independent of clk.

## Configuration
- PC_RVC_EN defined:
  - Targets need 2-byte alignment; misaligned means bit 0 = 1.
  - The increment honours is_compressed_i.
- PC_RVC_EN undefined:
  - Targets need 4-byte alignment; misaligned means bits [1:0] ≠ 0.
  - The increment is always 4; is_compressed_i is ignored.

## Structure
- A shared package holds:
  - the state enum (BOOT/RUN/FLUSH);
  - the ILEN_STD=4 and ILEN_C=2 constants;
  - the default RESET_VECTOR.
- One natural sub-module, pc_align_chk: a combinational misalignment detector selected by PC_RVC_EN.

## Test plan
- Reset release with RESET_VECTOR=0x100 and fetch_ready_i=1:
  - first valid cycle shows pc_o=0x100, epoch_o=0;
  - next cycles show 0x104 and 0x108.
- fetch_ready_i low for 3 cycles at pc_o=0x200: pc_o stays 0x200 and pc_valid_o stays 1; the PC advances to 0x204 after ready returns.
- Redirect to 0x400 during stall_i=1: the next cycle shows pc_o=0x400 and pc_valid_o=0; the one after shows pc_valid_o=1 and epoch_o incremented by 1.
- trap_i together with redirect_valid_i, mtvec_i=0x80000003: pc_o=0x80000000; the redirect is ignored; epoch increments once.
- Redirect to 0x402 without PC_RVC_EN: misalign_o pulses for 1 cycle and pc_o is unchanged. With PC_RVC_EN, the same redirect is accepted, and is_compressed_i=1 then gives 0x404.
- pc_o=0xFFFFFFFC with a transfer: pc_o=0x0. Four redirects from epoch 3 with EPOCH_W=2: epoch goes 0,1,2,3.
